// File: rtl/chess_turn_clock_pkg.sv
// Shared types, constants and countdown helpers for the chess turn clock.
package chess_turn_clock_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned BCD_W = 4;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   typedef logic [BCD_W-1:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN_WHITE = 2'd1,
      RUN_BLACK = 2'd2,
      TIMEOUT   = 2'd3
   } state_t;

   // One player's remaining time as M:SS digits
   typedef struct packed {
      bcd_t mins;
      bcd_t tens;
      bcd_t units;
   } clk_time_t;

   // True when the time shows 0:00
   function automatic logic is_zero(input clk_time_t t);
      return (t == '0);
   endfunction

   // One-second BCD countdown; saturates at 0:00
   function automatic clk_time_t dec_time(input clk_time_t t);
      clk_time_t r;
      r = t;
      if (!is_zero(t)) begin
         if (t.units != 4'd0) begin
            r.units = t.units - 4'd1;
         end else begin
            r.units = 4'd9;
            if (t.tens != 4'd0) begin
               r.tens = t.tens - 4'd1;
            end else begin
               r.tens = 4'd5;
               r.mins = t.mins - 4'd1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_to_seven_seg.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module bcd_to_seven_seg
   import chess_turn_clock_pkg::*;
(
   input  bcd_t             digit,
   output logic [SEG_W-1:0] seg_c
);

   // Digit decode; codes above 9 blank the display
   always_comb begin
      seg_c = SEG_BLANK;
      case (digit)
         4'd0: seg_c = 7'h40;
         4'd1: seg_c = 7'h79;
         4'd2: seg_c = 7'h24;
         4'd3: seg_c = 7'h30;
         4'd4: seg_c = 7'h19;
         4'd5: seg_c = 7'h12;
         4'd6: seg_c = 7'h02;
         4'd7: seg_c = 7'h78;
         4'd8: seg_c = 7'h00;
         4'd9: seg_c = 7'h10;
         default: seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/chess_turn_clock.sv
// Two-player chess clock: counts the side to move down in M:SS, flips on
// moveDone, flags expiry, and drives six registered 7-segment displays.
module chess_turn_clock
   import chess_turn_clock_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned START_MINS = 5,
   parameter int unsigned START_SECS = 0
) (
   input  logic             clock,
   input  logic             globalReset,
   input  logic             timerEnable,
   input  logic             run,
   input  logic             moveDone,
   output logic             whiteToMove,
   output logic             whiteFlag,
   output logic             blackFlag,
   output logic [SEG_W-1:0] WhiteClockMins,
   output logic [SEG_W-1:0] WhiteClockTensSec,
   output logic [SEG_W-1:0] WhiteClockUnitsSec,
   output logic [SEG_W-1:0] BlackClockMins,
   output logic [SEG_W-1:0] BlackClockTensSec,
   output logic [SEG_W-1:0] BlackClockUnitsSec
);

   localparam int unsigned PRESC_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLOCK_FREQ - 1);
   localparam clk_time_t PRESET = {4'(START_MINS), 4'(START_SECS / 10), 4'(START_SECS % 10)};

   state_t               state, state_next;
   logic [PRESC_W-1:0]   presc, presc_next;
   clk_time_t            white_time, white_next;
   clk_time_t            black_time, black_next;
   logic                 white_flag_next, black_flag_next, wtm_next;
   logic                 active, tick, flip;
   logic [SEG_W-1:0]     seg_wm_c, seg_wt_c, seg_wu_c, seg_bm_c, seg_bt_c, seg_bu_c;

   // A running state stops doing work once either flag is up; TIMEOUT follows
   assign active = ((state == RUN_WHITE) || (state == RUN_BLACK)) && !(whiteFlag || blackFlag);
   assign tick   = active && run && (presc == PRESC_MAX);
   assign flip   = active && moveDone;

   // State, time, flag and side registers
   always_ff @(posedge clock) begin
      if (globalReset) begin
         state       <= IDLE;
         presc       <= '0;
         white_time  <= PRESET;
         black_time  <= PRESET;
         whiteFlag   <= 1'b0;
         blackFlag   <= 1'b0;
         whiteToMove <= 1'b1;
      end else begin
         state       <= state_next;
         presc       <= presc_next;
         white_time  <= white_next;
         black_time  <= black_next;
         whiteFlag   <= white_flag_next;
         blackFlag   <= black_flag_next;
         whiteToMove <= wtm_next;
      end
   end

   // Next state, prescaler, countdown and flag logic
   always_comb begin
      state_next      = state;
      presc_next      = presc;
      white_next      = white_time;
      black_next      = black_time;
      white_flag_next = whiteFlag;
      black_flag_next = blackFlag;
      wtm_next        = whiteToMove;

      if (!timerEnable) begin
         state_next      = IDLE;
         presc_next      = '0;
         white_next      = PRESET;
         black_next      = PRESET;
         white_flag_next = 1'b0;
         black_flag_next = 1'b0;
         wtm_next        = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (run) begin
                  state_next = RUN_WHITE;
                  wtm_next   = 1'b1;
               end
            end
            RUN_WHITE, RUN_BLACK: begin
               if (!active) begin
                  state_next = TIMEOUT;
                  presc_next = '0;
               end else begin
                  // Decrement lands on the side that was to move, even when flipping
                  if (state == RUN_WHITE) begin
                     if (tick) white_next = dec_time(white_time);
                     if (is_zero(white_next)) white_flag_next = 1'b1;
                  end else begin
                     if (tick) black_next = dec_time(black_time);
                     if (is_zero(black_next)) black_flag_next = 1'b1;
                  end
                  if (flip) begin
                     presc_next = '0;
                     state_next = (state == RUN_WHITE) ? RUN_BLACK : RUN_WHITE;
                     wtm_next   = (state == RUN_BLACK);
                  end else if (run) begin
                     presc_next = tick ? '0 : presc + PRESC_W'(1);
                  end
               end
            end
            TIMEOUT: begin
               state_next = TIMEOUT;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   bcd_to_seven_seg u_seg_wm (.digit(white_time.mins),  .seg_c(seg_wm_c));
   bcd_to_seven_seg u_seg_wt (.digit(white_time.tens),  .seg_c(seg_wt_c));
   bcd_to_seven_seg u_seg_wu (.digit(white_time.units), .seg_c(seg_wu_c));
   bcd_to_seven_seg u_seg_bm (.digit(black_time.mins),  .seg_c(seg_bm_c));
   bcd_to_seven_seg u_seg_bt (.digit(black_time.tens),  .seg_c(seg_bt_c));
   bcd_to_seven_seg u_seg_bu (.digit(black_time.units), .seg_c(seg_bu_c));

   // Display registers: one cycle behind the digit registers
   always_ff @(posedge clock) begin
      WhiteClockMins     <= seg_wm_c;
      WhiteClockTensSec  <= seg_wt_c;
      WhiteClockUnitsSec <= seg_wu_c;
      BlackClockMins     <= seg_bm_c;
      BlackClockTensSec  <= seg_bt_c;
      BlackClockUnitsSec <= seg_bu_c;
   end

endmodule

// File: tb/tb_chess_turn_clock.sv
// Bench for chess_turn_clock: two instances (5:00 and 0:02 presets) share
// stimulus; a seconds-based model is checked every cycle, plus literal checks.
module tb_chess_turn_clock;

   localparam int F = 4;

   logic clock = 1'b0;
   logic rst = 1'b1, en = 1'b0, run = 1'b0, md = 1'b0;

   logic       a_wtm, a_wf, a_bf, b_wtm, b_wf, b_bf;
   logic [6:0] a_wm, a_wt, a_wu, a_bm, a_bt, a_bu;
   logic [6:0] b_wm, b_wt, b_wu, b_bm, b_bt, b_bu;

   int n_cmp = 0;
   int n_bad = 0;

   chess_turn_clock #(.CLOCK_FREQ(F), .START_MINS(5), .START_SECS(0)) dut_a (
      .clock(clock), .globalReset(rst), .timerEnable(en), .run(run), .moveDone(md),
      .whiteToMove(a_wtm), .whiteFlag(a_wf), .blackFlag(a_bf),
      .WhiteClockMins(a_wm), .WhiteClockTensSec(a_wt), .WhiteClockUnitsSec(a_wu),
      .BlackClockMins(a_bm), .BlackClockTensSec(a_bt), .BlackClockUnitsSec(a_bu));

   chess_turn_clock #(.CLOCK_FREQ(F), .START_MINS(0), .START_SECS(2)) dut_b (
      .clock(clock), .globalReset(rst), .timerEnable(en), .run(run), .moveDone(md),
      .whiteToMove(b_wtm), .whiteFlag(b_wf), .blackFlag(b_bf),
      .WhiteClockMins(b_wm), .WhiteClockTensSec(b_wt), .WhiteClockUnitsSec(b_wu),
      .BlackClockMins(b_bm), .BlackClockTensSec(b_bt), .BlackClockUnitsSec(b_bu));

   initial forever #5 clock = ~clock;

   // ---------------- model: remaining time in whole seconds ----------------
   int         start_secs [2] = '{300, 2};
   int         m_rem_w [2], m_rem_b [2], m_mode [2], m_phase [2];   // mode 0 idle, 1 running, 2 timed out
   bit         m_wtm [2], m_wf [2], m_bf [2];
   logic [6:0] m_disp [2][6];
   int         steps = 0;

   function automatic logic [6:0] seg7(input int d);
      logic [6:0] tbl [10];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return (d >= 0 && d <= 9) ? tbl[d] : 7'h7F;
   endfunction

   task automatic model_step(input int k);
      bit tick;
      if (rst || !en) begin
         m_mode[k]  = 0;
         m_rem_w[k] = start_secs[k];
         m_rem_b[k] = start_secs[k];
         m_wtm[k]   = 1'b1;
         m_wf[k]    = 1'b0;
         m_bf[k]    = 1'b0;
         m_phase[k] = 0;
      end else if (m_mode[k] == 0) begin
         if (run) m_mode[k] = 1;
      end else if (m_mode[k] == 1) begin
         if (m_wf[k] || m_bf[k]) begin
            m_mode[k]  = 2;
            m_phase[k] = 0;
         end else begin
            tick = run && (m_phase[k] == F - 1);
            if (m_wtm[k]) begin
               if (tick && m_rem_w[k] > 0) m_rem_w[k] = m_rem_w[k] - 1;
               if (m_rem_w[k] == 0) m_wf[k] = 1'b1;
            end else begin
               if (tick && m_rem_b[k] > 0) m_rem_b[k] = m_rem_b[k] - 1;
               if (m_rem_b[k] == 0) m_bf[k] = 1'b1;
            end
            if (md) m_phase[k] = 0;
            else if (run) m_phase[k] = (m_phase[k] + 1) % F;
            if (md) m_wtm[k] = !m_wtm[k];
         end
      end
   endtask

   // Displays latch the digits held before each edge, then the model advances
   always @(posedge clock) begin
      for (int k = 0; k < 2; k++) begin
         m_disp[k][0] = seg7(m_rem_w[k] / 60);
         m_disp[k][1] = seg7((m_rem_w[k] % 60) / 10);
         m_disp[k][2] = seg7(m_rem_w[k] % 10);
         m_disp[k][3] = seg7(m_rem_b[k] / 60);
         m_disp[k][4] = seg7((m_rem_b[k] % 60) / 10);
         m_disp[k][5] = seg7(m_rem_b[k] % 10);
         model_step(k);
      end
      steps = steps + 1;
   end

   // ---------------- checking ----------------
   task automatic cmp(input string name, input int act, input int exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clock) begin
      if (steps >= 1) begin
         cmp("A.whiteToMove", a_wtm, m_wtm[0]);
         cmp("A.whiteFlag",   a_wf,  m_wf[0]);
         cmp("A.blackFlag",   a_bf,  m_bf[0]);
         cmp("B.whiteToMove", b_wtm, m_wtm[1]);
         cmp("B.whiteFlag",   b_wf,  m_wf[1]);
         cmp("B.blackFlag",   b_bf,  m_bf[1]);
      end
      if (steps >= 2) begin
         cmp("A.WhiteMins",  a_wm, m_disp[0][0]);
         cmp("A.WhiteTens",  a_wt, m_disp[0][1]);
         cmp("A.WhiteUnits", a_wu, m_disp[0][2]);
         cmp("A.BlackMins",  a_bm, m_disp[0][3]);
         cmp("A.BlackTens",  a_bt, m_disp[0][4]);
         cmp("A.BlackUnits", a_bu, m_disp[0][5]);
         cmp("B.WhiteMins",  b_wm, m_disp[1][0]);
         cmp("B.WhiteTens",  b_wt, m_disp[1][1]);
         cmp("B.WhiteUnits", b_wu, m_disp[1][2]);
         cmp("B.BlackMins",  b_bm, m_disp[1][3]);
         cmp("B.BlackTens",  b_bt, m_disp[1][4]);
         cmp("B.BlackUnits", b_bu, m_disp[1][5]);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus with literal checks ----------------
   initial begin
      cycles(3);
      rst = 1'b0;
      cycles(1);
      cmp("lit reset A.WhiteMins 5",  a_wm, 7'h12);
      cmp("lit reset A.WhiteTens 0",  a_wt, 7'h40);
      cmp("lit reset A.BlackUnits 0", a_bu, 7'h40);
      cmp("lit reset A.whiteToMove",  a_wtm, 1);
      cmp("lit reset A.whiteFlag",    a_wf, 0);
      cmp("lit reset B.WhiteUnits 2", b_wu, 7'h24);

      en = 1'b1; run = 1'b1;
      cycles(6);
      cmp("lit 4:59 A.WhiteMins",  a_wm, 7'h19);
      cmp("lit 4:59 A.WhiteTens",  a_wt, 7'h12);
      cmp("lit 4:59 A.WhiteUnits", a_wu, 7'h10);
      cmp("lit 5:00 A.BlackMins",  a_bm, 7'h12);
      cmp("lit 0:01 B.WhiteUnits", b_wu, 7'h79);

      cycles(40);
      cmp("lit 4:49 A.WhiteTens",  a_wt, 7'h19);
      cmp("lit 4:49 A.WhiteUnits", a_wu, 7'h10);
      cmp("lit B timeout whiteFlag", b_wf, 1);
      cmp("lit B timeout WhiteUnits", b_wu, 7'h40);

      md = 1'b1;
      cycles(1);
      md = 1'b0;
      cmp("lit flip A.whiteToMove", a_wtm, 0);
      cmp("lit B ignores moveDone", b_wtm, 1);
      cycles(4);
      cmp("lit black not yet A.BlackUnits", a_bu, 7'h40);
      cycles(1);
      cmp("lit black 4:59 A.BlackUnits", a_bu, 7'h10);
      cmp("lit white held A.WhiteTens",  a_wt, 7'h19);

      run = 1'b0;
      cycles(10);
      cmp("lit paused A.BlackUnits", a_bu, 7'h10);
      run = 1'b1;
      cycles(3);
      cmp("lit resume pending A.BlackUnits", a_bu, 7'h10);
      cycles(1);
      cmp("lit resume 4:58 A.BlackUnits", a_bu, 7'h00);

      cycles(2);
      md = 1'b1;
      cycles(1);
      md = 1'b0;
      cmp("lit tick+move A.whiteToMove", a_wtm, 1);
      cycles(1);
      cmp("lit tick+move A.BlackUnits 7", a_bu, 7'h78);
      cmp("lit tick+move A.WhiteUnits 9", a_wu, 7'h10);

      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      cmp("lit mid reset B.whiteFlag",   b_wf, 0);
      cmp("lit mid reset A.whiteToMove", a_wtm, 1);
      cycles(1);
      cmp("lit mid reset B.WhiteUnits 2", b_wu, 7'h24);
      cmp("lit mid reset B.BlackUnits 2", b_bu, 7'h24);
      cmp("lit mid reset A.BlackUnits 0", a_bu, 7'h40);

      // Mixed traffic: pauses, moves and occasional disable
      for (int i = 0; i < 300; i++) begin
         run = ($urandom_range(0, 3) != 0);
         md  = ($urandom_range(0, 7) == 0);
         en  = ($urandom_range(0, 59) != 0);
         cycles(1);
      end
      md = 1'b0; en = 1'b0;
      cycles(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
